// File: rtl/rbb_pingpong.sv
// rbb_pingpong: packs 32-bit result words into wide lines, ping-pong banked batches.
// Define RBB_PINGPONG_HDR_EN to prepend a count/sequence header line to each drain.
module rbb_pingpong #(
  parameter int RD_ADDR_WIDTH = 8,
  parameter int RD_DATA_WIDTH = 512,
  parameter int WR_DATA_WIDTH = 32,
  parameter int PACK_LOG2     = 4,
  parameter int WR_ADDR_WIDTH = RD_ADDR_WIDTH + PACK_LOG2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     task_done,
  input  logic                     WrEn,
  input  logic [WR_ADDR_WIDTH-1:0] WrAddr,
  input  logic [WR_DATA_WIDTH-1:0] WrDin,
  output logic                     Full,
  output logic                     Empty,
  output logic                     ReqValid,
  output logic [RD_ADDR_WIDTH-1:0] ReqLineIdx,
  output logic [RD_DATA_WIDTH-1:0] RdDout,
  input  logic                     ReqAck,
  output logic [RD_ADDR_WIDTH:0]   BatchLines,
  output logic                     BatchDone,
  output logic                     Overflow
);

  localparam int LINES = 1 << RD_ADDR_WIDTH;
  localparam int DEPTH = 2 * LINES;
  localparam int CW    = RD_ADDR_WIDTH + 1;
`ifdef RBB_PINGPONG_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, VALID} state_t;

  logic [RD_DATA_WIDTH-1:0] mem [DEPTH];
  logic [RD_DATA_WIDTH-1:0] mem_q;
  logic [DEPTH-1:0]         lv;
  logic                     rd_vld;

  logic [1:0]               ready;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [RD_DATA_WIDTH-1:0] stage_data;
  logic [RD_ADDR_WIDTH-1:0] stage_line;
  logic                     stage_any;
  logic                     commit_q;
  logic                     close_q;
  logic [CW-1:0]            fill_cnt;
  logic [CW-1:0]            bank_cnt [2];
  logic                     overflow;

  state_t                   state;
  logic [RD_ADDR_WIDTH-1:0] rd_idx;
  logic [CW-1:0]            batch_lines;
  logic                     batch_done;

  logic [PACK_LOG2-1:0]     wr_lane;
  logic [RD_ADDR_WIDTH-1:0] wr_line;
  logic                     full_blk;
  logic                     line_bad;
  logic                     wr_ok;
  logic                     td_ok;
  logic                     do_commit;
  logic [CW-1:0]            line_p1;
  logic [CW-1:0]            cnt_c;
  logic [RD_DATA_WIDTH-1:0] stage_d;
  logic                     stage_any_d;
  logic                     close_now;
  logic                     close_d;
  logic                     last;
  logic                     rd_en;
  logic [RD_ADDR_WIDTH-1:0] rd_line;
  logic [RD_ADDR_WIDTH:0]   rd_addr;

  assign wr_lane = WrAddr[PACK_LOG2-1:0];
  assign wr_line = WrAddr[WR_ADDR_WIDTH-1:PACK_LOG2];

`ifdef RBB_PINGPONG_HDR_EN
  assign line_bad = (wr_line == {RD_ADDR_WIDTH{1'b1}});
`else
  assign line_bad = 1'b0;
`endif

  // A bank closing this cycle hands writes to the other bank, which may still be draining.
  always_comb begin
    full_blk = ready[wr_bank] || (close_q && ready[~wr_bank]);
    wr_ok = WrEn && !full_blk && !line_bad;
    td_ok = task_done && !full_blk;
    do_commit = commit_q || (close_q && stage_any);
    line_p1 = {1'b0, stage_line} + CW'(1);
    cnt_c = (do_commit && line_p1 > fill_cnt) ? line_p1 : fill_cnt;
    stage_d = do_commit ? '0 : stage_data;
    if (wr_ok)
      stage_d[wr_lane*WR_DATA_WIDTH +: WR_DATA_WIDTH] = WrDin;
    stage_any_d = (stage_any && !do_commit) || wr_ok;
    close_now = close_q ||
                (td_ok && !stage_any_d && cnt_c != '0);
    close_d = td_ok && stage_any_d;
  end

  always_comb begin
    last = ({1'b0, rd_idx} == batch_lines - CW'(1));
    rd_en = 1'b0;
    rd_line = '0;
    unique case (state)
      LOAD: rd_en = 1'b1;
      VALID: begin
        rd_en = ReqAck && !last;
        rd_line = rd_idx + RD_ADDR_WIDTH'(1 - HDR);
      end
      default: rd_en = 1'b0;
    endcase
    rd_addr = {rd_bank, rd_line};
  end

  always_ff @(posedge clk) begin
    if (do_commit)
      mem[{wr_bank, stage_line}] <= stage_data;
    if (rd_en)
      mem_q <= mem[rd_addr];
  end

`ifdef RBB_PINGPONG_HDR_EN
  logic [15:0]              seq;
  logic                     hdr_sel;
  logic [RD_DATA_WIDTH-1:0] hdr_word;

  always_comb begin
    hdr_word = '0;
    hdr_word[RD_ADDR_WIDTH:0] = batch_lines - CW'(1);
    hdr_word[RD_ADDR_WIDTH+16:RD_ADDR_WIDTH+1] = seq;
  end

  assign RdDout = hdr_sel ? hdr_word : (rd_vld ? mem_q : '0);
`else
  assign RdDout = rd_vld ? mem_q : '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready       <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      stage_data  <= '0;
      stage_line  <= '0;
      stage_any   <= 1'b0;
      commit_q    <= 1'b0;
      close_q     <= 1'b0;
      fill_cnt    <= '0;
      bank_cnt[0] <= '0;
      bank_cnt[1] <= '0;
      overflow    <= 1'b0;
      lv          <= '0;
      rd_vld      <= 1'b0;
      state       <= IDLE;
      rd_idx      <= '0;
      batch_lines <= '0;
      batch_done  <= 1'b0;
`ifdef RBB_PINGPONG_HDR_EN
      seq         <= '0;
      hdr_sel     <= 1'b0;
`endif
    end else begin
      stage_data <= stage_d;
      if (wr_ok)
        stage_line <= wr_line;
      stage_any <= stage_any_d;
      commit_q  <= wr_ok && (wr_lane == {PACK_LOG2{1'b1}});
      close_q   <= close_d;
      if ((WrEn && (full_blk || line_bad)) || (task_done && full_blk))
        overflow <= 1'b1;
      if (do_commit)
        lv[{wr_bank, stage_line}] <= 1'b1;
      fill_cnt <= close_now ? '0 : cnt_c;
      if (close_now) begin
        ready[wr_bank]    <= 1'b1;
        bank_cnt[wr_bank] <= cnt_c;
        wr_bank           <= ~wr_bank;
      end
      if (rd_en)
        rd_vld <= lv[rd_addr];
      batch_done <= 1'b0;
      unique case (state)
        IDLE: if (ready[rd_bank]) state <= LOAD;
        LOAD: begin
          state       <= VALID;
          rd_idx      <= '0;
          batch_lines <= bank_cnt[rd_bank] + CW'(HDR);
`ifdef RBB_PINGPONG_HDR_EN
          hdr_sel     <= 1'b1;
`endif
        end
        VALID: if (ReqAck) begin
`ifdef RBB_PINGPONG_HDR_EN
          hdr_sel <= 1'b0;
`endif
          if (last) begin
            ready[rd_bank]              <= 1'b0;
            lv[rd_bank*LINES +: LINES] <= '0;
            rd_bank                     <= ~rd_bank;
            batch_done                  <= 1'b1;
            rd_idx                      <= '0;
            state                       <= IDLE;
`ifdef RBB_PINGPONG_HDR_EN
            seq                         <= seq + 16'd1;
`endif
          end else begin
            rd_idx <= rd_idx + RD_ADDR_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Full       = ready[wr_bank];
  assign Empty      = !ready[0] && !ready[1] && (state == IDLE);
  assign ReqValid   = (state == VALID);
  assign ReqLineIdx = rd_idx;
  assign BatchLines = batch_lines;
  assign BatchDone  = batch_done;
  assign Overflow   = overflow;

endmodule

// File: tb/tb_rbb_pingpong.sv
// tb_rbb_pingpong: directed scenarios for the ping-pong result batch buffer.
// Header-mode scenario runs instead of the plain scenarios when RBB_PINGPONG_HDR_EN is set.
module tb_rbb_pingpong;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         task_done;
  logic         WrEn;
  logic [11:0]  WrAddr;
  logic [31:0]  WrDin;
  logic         Full;
  logic         Empty;
  logic         ReqValid;
  logic [7:0]   ReqLineIdx;
  logic [511:0] RdDout;
  logic         ReqAck;
  logic [8:0]   BatchLines;
  logic         BatchDone;
  logic         Overflow;

  int n_tests = 0;
  int n_fail  = 0;

  rbb_pingpong dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .task_done  (task_done),
    .WrEn       (WrEn),
    .WrAddr     (WrAddr),
    .WrDin      (WrDin),
    .Full       (Full),
    .Empty      (Empty),
    .ReqValid   (ReqValid),
    .ReqLineIdx (ReqLineIdx),
    .RdDout     (RdDout),
    .ReqAck     (ReqAck),
    .BatchLines (BatchLines),
    .BatchDone  (BatchDone),
    .Overflow   (Overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] exp_line(input logic [31:0] tag, input int line);
    logic [511:0] v;
    for (int l = 0; l < 16; l++)
      v[l*32 +: 32] = tag | 32'(line * 16 + l);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    WrEn = 1'b1;
    WrAddr = a;
    WrDin = d;
    tick();
    WrEn = 1'b0;
  endtask

  task automatic fill(input logic [31:0] tag, input int nlines);
    for (int i = 0; i < nlines * 16; i++)
      wr(12'(i), tag | 32'(i));
  endtask

  task automatic done_pulse();
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
  endtask

  task automatic ack_pulse();
    ReqAck = 1'b1;
    tick();
    ReqAck = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (ReqValid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    task_done = 1'b0;
    WrEn = 1'b0;
    WrAddr = '0;
    WrDin = '0;
    ReqAck = 1'b0;
    tick();
    tick();
    n_tests++;
    if (ReqValid !== 1'b0 || ReqLineIdx !== 8'd0 || RdDout !== 512'd0) begin
      n_fail++;
      $display("FAIL reset_req: valid=%b idx=%0d dout_nz=%b want 0/0/0",
               ReqValid, ReqLineIdx, |RdDout);
    end
    n_tests++;
    if ({BatchLines, BatchDone, Overflow, Full, Empty} !== 13'b0000000000001) begin
      n_fail++;
      $display("FAIL reset_status: lines=%0d done=%b ovf=%b full=%b empty=%b want 0/0/0/0/1",
               BatchLines, BatchDone, Overflow, Full, Empty);
    end
    reset_n = 1'b1;
    tick();
    done_pulse();
    repeat (4) tick();
    n_tests++;
    if (Empty !== 1'b1 || ReqValid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_task_done: empty=%b valid=%b want 1/0", Empty, ReqValid);
    end
  endtask

  task automatic test_basic();
    logic [2:0] vseq;
    fill(32'h0, 2);
    tick();
    done_pulse();
    vseq[2] = ReqValid;
    tick();
    vseq[1] = ReqValid;
    tick();
    vseq[0] = ReqValid;
    n_tests++;
    if (vseq !== 3'b001) begin
      n_fail++;
      $display("FAIL basic_latency: valid T+1..T+3 got %b want 001", vseq);
    end
    n_tests++;
    if (ReqLineIdx !== 8'd0 || RdDout !== exp_line(32'h0, 0)) begin
      n_fail++;
      $display("FAIL basic_line0: idx=%0d dout=%h want idx 0 dout %h",
               ReqLineIdx, RdDout, exp_line(32'h0, 0));
    end
    n_tests++;
    if (BatchLines !== 9'd2) begin
      n_fail++;
      $display("FAIL basic_lines: got %0d want 2", BatchLines);
    end
    ack_pulse();
    n_tests++;
    if (ReqLineIdx !== 8'd1 || RdDout !== exp_line(32'h0, 1) || BatchDone !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_line1: idx=%0d done=%b dout=%h want idx 1 done 0 dout %h",
               ReqLineIdx, BatchDone, RdDout, exp_line(32'h0, 1));
    end
    ack_pulse();
    n_tests++;
    if (BatchDone !== 1'b1 || ReqValid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b valid=%b want 1/0", BatchDone, ReqValid);
    end
    tick();
    n_tests++;
    if (BatchDone !== 1'b0 || Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_after: done=%b empty=%b want 0/1", BatchDone, Empty);
    end
  endtask

  task automatic test_partial();
    logic [1:0]   v;
    logic [511:0] e;
    for (int l = 0; l < 5; l++)
      wr(12'(48 + l), 32'hA000_0000 | 32'(l));
    done_pulse();
    tick();
    tick();
    v[1] = ReqValid;
    tick();
    v[0] = ReqValid;
    n_tests++;
    if (v !== 2'b01) begin
      n_fail++;
      $display("FAIL partial_latency: valid T+3,T+4 got %b want 01", v);
    end
    n_tests++;
    if (BatchLines !== 9'd4) begin
      n_fail++;
      $display("FAIL partial_lines: got %0d want 4", BatchLines);
    end
    for (int i = 0; i < 4; i++) begin
      e = '0;
      if (i == 3)
        for (int l = 0; l < 5; l++)
          e[l*32 +: 32] = 32'hA000_0000 | 32'(l);
      n_tests++;
      if (ReqLineIdx !== 8'(i) || RdDout !== e) begin
        n_fail++;
        $display("FAIL partial_line%0d: idx=%0d dout=%h want %h", i, ReqLineIdx, RdDout, e);
      end
      ack_pulse();
    end
    n_tests++;
    if (BatchDone !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_done: got %b want 1", BatchDone);
    end
  endtask

  task automatic test_full();
    int           cyc;
    int           errs;
    logic [31:0]  tag;
    fill(32'h1000_0000, 16);
    tick();
    done_pulse();
    fill(32'h2000_0000, 16);
    tick();
    done_pulse();
    tick();
    n_tests++;
    if (Full !== 1'b1 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flag: full=%b ovf=%b want 1/0", Full, Overflow);
    end
    wr(12'h000, 32'hDEAD_BEEF);
    n_tests++;
    if (Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL full_overflow: got %b want 1", Overflow);
    end
    done_pulse();
    for (int b = 0; b < 2; b++) begin
      tag = (b == 0) ? 32'h1000_0000 : 32'h2000_0000;
      wait_valid(cyc);
      n_tests++;
      if (ReqValid !== 1'b1 || BatchLines !== 9'd16) begin
        n_fail++;
        $display("FAIL full_bank%0d_start: valid=%b lines=%0d want 1/16", b, ReqValid, BatchLines);
      end
      errs = 0;
      for (int i = 0; i < 16; i++) begin
        if (ReqValid !== 1'b1 || ReqLineIdx !== 8'(i) || RdDout !== exp_line(tag, i)) begin
          if (errs == 0)
            $display("FAIL full_bank%0d_line%0d: idx=%0d dout=%h want %h",
                     b, i, ReqLineIdx, RdDout, exp_line(tag, i));
          errs++;
        end
        ack_pulse();
      end
      n_tests++;
      if (errs != 0) begin
        n_fail++;
        $display("FAIL full_bank%0d_data: %0d bad lines want 0", b, errs);
      end
      n_tests++;
      if (BatchDone !== 1'b1) begin
        n_fail++;
        $display("FAIL full_bank%0d_done: got %b want 1", b, BatchDone);
      end
    end
    tick();
    n_tests++;
    if (Empty !== 1'b1 || Overflow !== 1'b1 || Full !== 1'b0) begin
      n_fail++;
      $display("FAIL full_after: empty=%b ovf=%b full=%b want 1/1/0", Empty, Overflow, Full);
    end
  endtask

  task automatic test_back_to_back();
    int          cyc;
    int          errs;
    int          dones;
    logic [31:0] tag;
    tag = 32'h5000_0000;
    fill(tag, 256);
    tick();
    done_pulse();
    wait_valid(cyc);
    n_tests++;
    if (ReqValid !== 1'b1 || BatchLines !== 9'd256) begin
      n_fail++;
      $display("FAIL b2b_start: valid=%b lines=%0d want 1/256", ReqValid, BatchLines);
    end
    ReqAck = 1'b1;
    errs = 0;
    dones = 0;
    for (int i = 0; i < 256; i++) begin
      if (ReqValid !== 1'b1 || ReqLineIdx !== 8'(i) || RdDout !== exp_line(tag, i)) begin
        if (errs == 0)
          $display("FAIL b2b_line%0d: valid=%b idx=%0d", i, ReqValid, ReqLineIdx);
        errs++;
      end
      if (BatchDone === 1'b1)
        dones++;
      tick();
    end
    ReqAck = 1'b0;
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL b2b_seq: %0d bad cycles want 0", errs);
    end
    n_tests++;
    if (BatchDone !== 1'b1 || ReqValid !== 1'b0 || dones != 0) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b valid=%b early=%0d want 1/0/0", BatchDone, ReqValid, dones);
    end
    tick();
    n_tests++;
    if (BatchDone !== 1'b0 || Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_after: done=%b empty=%b want 0/1", BatchDone, Empty);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    fill(32'h6000_0000, 8);
    tick();
    done_pulse();
    wait_valid(cyc);
    repeat (7) ack_pulse();
    n_tests++;
    if (ReqLineIdx !== 8'd7 || RdDout !== exp_line(32'h6000_0000, 7)) begin
      n_fail++;
      $display("FAIL mid_line7: idx=%0d want 7", ReqLineIdx);
    end
    reset_n = 1'b0;
    tick();
    n_tests++;
    if (ReqValid !== 1'b0 || ReqLineIdx !== 8'd0 || RdDout !== 512'd0) begin
      n_fail++;
      $display("FAIL mid_reset_req: valid=%b idx=%0d dout_nz=%b want 0/0/0",
               ReqValid, ReqLineIdx, |RdDout);
    end
    n_tests++;
    if ({BatchLines, BatchDone, Overflow, Full, Empty} !== 13'b0000000000001) begin
      n_fail++;
      $display("FAIL mid_reset_status: lines=%0d done=%b ovf=%b full=%b empty=%b want 0/0/0/0/1",
               BatchLines, BatchDone, Overflow, Full, Empty);
    end
    reset_n = 1'b1;
    fill(32'h7000_0000, 1);
    tick();
    done_pulse();
    wait_valid(cyc);
    n_tests++;
    if (ReqValid !== 1'b1 || ReqLineIdx !== 8'd0 || BatchLines !== 9'd1 ||
        RdDout !== exp_line(32'h7000_0000, 0)) begin
      n_fail++;
      $display("FAIL mid_new_batch: valid=%b idx=%0d lines=%0d dout=%h want 1/0/1 %h",
               ReqValid, ReqLineIdx, BatchLines, RdDout, exp_line(32'h7000_0000, 0));
    end
    ack_pulse();
    n_tests++;
    if (BatchDone !== 1'b1 || Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_new_done: done=%b empty=%b want 1/1", BatchDone, Empty);
    end
  endtask

  task automatic test_header();
    int           cyc;
    logic [31:0]  tag;
    logic [511:0] h;
    for (int b = 0; b < 2; b++) begin
      tag = (b == 0) ? 32'h8000_0000 : 32'h9000_0000;
      fill(tag, 2);
      tick();
      done_pulse();
      wait_valid(cyc);
      h = '0;
      h[8:0] = 9'd2;
      h[24:9] = 16'(b);
      n_tests++;
      if (ReqValid !== 1'b1 || ReqLineIdx !== 8'd0 || RdDout !== h || BatchLines !== 9'd3) begin
        n_fail++;
        $display("FAIL hdr%0d_header: idx=%0d lines=%0d dout=%h want 0/3 %h",
                 b, ReqLineIdx, BatchLines, RdDout, h);
      end
      for (int i = 1; i < 3; i++) begin
        ack_pulse();
        n_tests++;
        if (ReqLineIdx !== 8'(i) || RdDout !== exp_line(tag, i - 1)) begin
          n_fail++;
          $display("FAIL hdr%0d_line%0d: idx=%0d dout=%h want %h",
                   b, i, ReqLineIdx, RdDout, exp_line(tag, i - 1));
        end
      end
      ack_pulse();
      n_tests++;
      if (BatchDone !== 1'b1) begin
        n_fail++;
        $display("FAIL hdr%0d_done: got %b want 1", b, BatchDone);
      end
    end
    wr(12'hFF0, 32'h1);
    n_tests++;
    if (Overflow !== 1'b1 || Full !== 1'b0) begin
      n_fail++;
      $display("FAIL hdr_last_line: ovf=%b full=%b want 1/0", Overflow, Full);
    end
  endtask

  initial begin
    test_reset();
`ifdef RBB_PINGPONG_HDR_EN
    test_header();
`else
    test_basic();
    test_partial();
    test_full();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
